branch_predict_unit: RTL and testbench
======================================

// Module: branch_predict_unit
// PURPOSE
//  Resolves branches in EX and keeps a dynamic predictor for IF, parametrised in table depth and PC width.
//  IF reads a 2-bit saturating-counter branch history table (BHT) indexed by low PC bits.
//  EX resolves BTYPE against flags, flags a misprediction, selects the PC source and trains the BHT.
//  Saturating branch and mispredict counters give performance statistics.
// PARAMETERS
//  PC_W       8   PC / address width
//  BHT_DEPTH  16  BHT entries; power of 2, >=2; IDX_W = $clog2(BHT_DEPTH)
//  CNT_W      16  statistics counter width
// PORTS
//  clk            in   1      rising-edge clock
//  rst            in   1      synchronous active-high reset
//  if_pc          in   PC_W   fetch PC for lookup
//  if_pred_taken  out  1      MSB of BHT[if_pc[IDX_W-1:0]], combinational
//  ex_valid       in   1      EX holds a valid instruction
//  ex_btype       in   3      000 NONE, 001 JZ, 010 JN, 011 JC, 100 JV, 101 LOOP, 110 JMP/CALL, 111 RET/RTI
//  ex_flags       in   4      bit0 Z, bit1 N, bit2 C, bit3 V
//  ex_pc          in   PC_W   PC of the EX instruction (BHT training index)
//  ex_pred_taken  in   1      prediction carried down the pipe with the instruction
//  b_take         out  1      branch actually taken
//  pc_src         out  2      00 NORM, 01 FW (target), 10 DataB (RET), 11 RECOVER (ex_pc+1)
//  redirect       out  1      flush IF/ID and load the PC per pc_src
//  mispredict     out  1      conditional branch resolved opposite to ex_pred_taken
//  stat_clr       in   1      clear statistics counters
//  br_count       out  CNT_W  resolved conditional branches, saturating
//  mp_count       out  CNT_W  mispredictions, saturating
// BEHAVIOUR
//  Resolution is combinational from the EX inputs, so it adds no latency.
//   - take: JZ=Z, JN=N, JC=C, JV=V, LOOP=!Z, JMP=1, RET=1, NONE=0.
//   - Conditional types (001-101):
//     taken and !ex_pred_taken -> pc_src=FW, redirect=1, mispredict=1
//     !taken and ex_pred_taken -> pc_src=RECOVER, redirect=1, mispredict=1
//     correct prediction -> pc_src=NORM, redirect=0, mispredict=0
//   - JMP -> pc_src=FW, redirect=1; RET -> pc_src=DataB, redirect=1; mispredict=0 for both.
//   - ex_valid=0 or rst=1 -> b_take=0, pc_src=NORM, redirect=0, mispredict=0.
//  BHT training, at the clock edge when ex_valid and ex_btype is 001-101:
//   - idx = ex_pc[IDX_W-1:0]; taken -> counter+1 saturating at 11; not taken -> counter-1 saturating at 00.
//   - Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
//   - JMP, RET and NONE never touch the BHT.
//  Same-index lookup and update in one cycle: if_pred_taken returns the pre-update value; no bypass.
//  Aliasing of PCs with equal low bits is accepted; there is no tag.
//  Statistics, at the clock edge with ex_valid:
//   - Conditional branch -> br_count+1; also mispredict -> mp_count+1.
//   - Both counters hold at all-ones, with no wrap.
//   - stat_clr zeroes both counters and takes priority over an increment in the same cycle.
//  Reset: every BHT entry = 01, br_count = mp_count = 0.
//   - rst asserted mid-stream discards that cycle's training and increments.
//   - The first cycle after rst deasserts sees a clean table.
// TESTING
//  1. Reset, then sweep if_pc 0..BHT_DEPTH-1 -> if_pred_taken=0 everywhere; br_count=mp_count=0.
//  2. JZ, ex_pc=3, Z=1, pred=0 -> b_take=1, pc_src=01, redirect=1, mispredict=1.
//     Next cycle BHT[3]=10, if_pc=3 gives pred 1, mp_count=1.
//  3. LOOP, Z=1, pred=1 -> b_take=0, pc_src=11, redirect=1, mispredict=1.
//     Four further not-taken at one index -> counter holds at 00, with no underflow.
//  4. JMP, then RET, with any flags/pred -> pc_src 01 then 10, redirect=1, mispredict=0.
//     BHT and counters are unchanged.
//  5. Preload mp_count=2^CNT_W-1 via forced mispredicts (CNT_W=4) -> counter holds 15.
//     stat_clr together with a mispredict -> both counters 0.
//  6. ex_pc=if_pc=5 in the same cycle, with training to taken -> if_pred_taken shows the old value.
//     The following cycle shows the new value.
//     rst raised mid-sequence -> table back to 01.

Source files
------------

// File: rtl/branch_predict_unit.sv
// Branch resolution for EX plus a 2-bit saturating-counter branch history table for IF.
// Also keeps saturating counters of resolved conditional branches and mispredictions.
module branch_predict_unit #(
    parameter int PC_W      = 8,
    parameter int BHT_DEPTH = 16,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PC_W-1:0]  if_pc,
    output logic             if_pred_taken,
    input  logic             ex_valid,
    input  logic [2:0]       ex_btype,
    input  logic [3:0]       ex_flags,
    input  logic [PC_W-1:0]  ex_pc,
    input  logic             ex_pred_taken,
    output logic             b_take,
    output logic [1:0]       pc_src,
    output logic             redirect,
    output logic             mispredict,
    input  logic             stat_clr,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mp_count
);
    localparam int IDX_W = $clog2(BHT_DEPTH);

    localparam logic [2:0] BT_NONE = 3'b000;
    localparam logic [2:0] BT_JZ   = 3'b001;
    localparam logic [2:0] BT_JN   = 3'b010;
    localparam logic [2:0] BT_JC   = 3'b011;
    localparam logic [2:0] BT_JV   = 3'b100;
    localparam logic [2:0] BT_LOOP = 3'b101;
    localparam logic [2:0] BT_JMP  = 3'b110;
    localparam logic [2:0] BT_RET  = 3'b111;

    localparam logic [1:0] SRC_NORM    = 2'b00;
    localparam logic [1:0] SRC_FW      = 2'b01;
    localparam logic [1:0] SRC_DATAB   = 2'b10;
    localparam logic [1:0] SRC_RECOVER = 2'b11;

    logic [1:0]       bht_q [BHT_DEPTH];
    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] ex_idx;
    logic             cond_take;
    logic             is_cond;
    logic             train_en;
    logic [1:0]       train_cnt;
    logic [1:0]       train_cnt_d;
    logic [CNT_W-1:0] br_count_q, br_count_d;
    logic [CNT_W-1:0] mp_count_q, mp_count_d;
    logic             unused_pc_bits;

    assign if_idx         = if_pc[IDX_W-1:0];
    assign ex_idx         = ex_pc[IDX_W-1:0];
    assign unused_pc_bits = ^{if_pc[PC_W-1:IDX_W], ex_pc[PC_W-1:IDX_W]};

    // Lookup sees the stored value only; a same-cycle update is not bypassed.
    assign if_pred_taken = bht_q[if_idx][1];

    always_comb begin
        cond_take = 1'b0;
        is_cond   = 1'b0;
        unique case (ex_btype)
            BT_JZ:   begin cond_take = ex_flags[0];  is_cond = 1'b1; end
            BT_JN:   begin cond_take = ex_flags[1];  is_cond = 1'b1; end
            BT_JC:   begin cond_take = ex_flags[2];  is_cond = 1'b1; end
            BT_JV:   begin cond_take = ex_flags[3];  is_cond = 1'b1; end
            BT_LOOP: begin cond_take = !ex_flags[0]; is_cond = 1'b1; end
            BT_JMP:  cond_take = 1'b1;
            BT_RET:  cond_take = 1'b1;
            BT_NONE: cond_take = 1'b0;
            default: cond_take = 1'b0;
        endcase
    end

    always_comb begin
        b_take     = 1'b0;
        pc_src     = SRC_NORM;
        redirect   = 1'b0;
        mispredict = 1'b0;
        if (ex_valid && !rst) begin
            b_take = cond_take;
            if (is_cond) begin
                if (cond_take && !ex_pred_taken) begin
                    pc_src     = SRC_FW;
                    redirect   = 1'b1;
                    mispredict = 1'b1;
                end else if (!cond_take && ex_pred_taken) begin
                    pc_src     = SRC_RECOVER;
                    redirect   = 1'b1;
                    mispredict = 1'b1;
                end
            end else if (ex_btype == BT_JMP) begin
                pc_src   = SRC_FW;
                redirect = 1'b1;
            end else if (ex_btype == BT_RET) begin
                pc_src   = SRC_DATAB;
                redirect = 1'b1;
            end
        end
    end

    // Only conditional types train; the counter saturates at both ends.
    assign train_en  = ex_valid && is_cond;
    assign train_cnt = bht_q[ex_idx];

    always_comb begin
        train_cnt_d = train_cnt;
        if (cond_take) begin
            if (train_cnt != 2'b11) train_cnt_d = train_cnt + 2'd1;
        end else begin
            if (train_cnt != 2'b00) train_cnt_d = train_cnt - 2'd1;
        end
    end

    generate
        for (genvar gi = 0; gi < BHT_DEPTH; gi++) begin : g_bht
            always_ff @(posedge clk) begin
                if (rst) begin
                    bht_q[gi] <= 2'b01;
                end else if (train_en && (ex_idx == IDX_W'(gi))) begin
                    bht_q[gi] <= train_cnt_d;
                end
            end
        end
    endgenerate

    always_comb begin
        br_count_d = br_count_q;
        mp_count_d = mp_count_q;
        if (stat_clr) begin
            br_count_d = '0;
            mp_count_d = '0;
        end else if (train_en) begin
            if (!(&br_count_q)) br_count_d = br_count_q + 1'b1;
            if (mispredict && !(&mp_count_q)) mp_count_d = mp_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            br_count_q <= '0;
            mp_count_q <= '0;
        end else begin
            br_count_q <= br_count_d;
            mp_count_q <= mp_count_d;
        end
    end

    assign br_count = br_count_q;
    assign mp_count = mp_count_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed and random stimulus for branch_predict_unit, checked against an
// arithmetic reference model of the predictor table and statistics.
module tb_branch_predict_unit;
    localparam int PC_W      = 8;
    localparam int BHT_DEPTH = 16;
    localparam int CNT_W     = 4;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [PC_W-1:0]  if_pc = '0;
    logic             if_pred_taken;
    logic             ex_valid = 1'b0;
    logic [2:0]       ex_btype = '0;
    logic [3:0]       ex_flags = '0;
    logic [PC_W-1:0]  ex_pc = '0;
    logic             ex_pred_taken = 1'b0;
    logic             b_take;
    logic [1:0]       pc_src;
    logic             redirect;
    logic             mispredict;
    logic             stat_clr = 1'b0;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] mp_count;

    int checks = 0;
    int errors = 0;

    int m_bht [BHT_DEPTH];
    int m_br;
    int m_mp;

    branch_predict_unit #(.PC_W(PC_W), .BHT_DEPTH(BHT_DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
        .ex_valid(ex_valid), .ex_btype(ex_btype), .ex_flags(ex_flags), .ex_pc(ex_pc),
        .ex_pred_taken(ex_pred_taken), .b_take(b_take), .pc_src(pc_src),
        .redirect(redirect), .mispredict(mispredict), .stat_clr(stat_clr),
        .br_count(br_count), .mp_count(mp_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < BHT_DEPTH; i++) m_bht[i] = 1;
        m_br = 0;
        m_mp = 0;
    endtask

    // One clock of stimulus: check combinational outputs before the edge, then
    // advance the model and check the statistics after it.
    task automatic step(input logic r, input logic v, input logic [2:0] bt, input logic [3:0] fl,
                        input logic [PC_W-1:0] epc, input logic pr, input logic clr,
                        input logic [PC_W-1:0] ipc);
        bit cond, tk, e_take, e_red, e_mp;
        int e_src, ei;
        @(negedge clk);
        rst = r; ex_valid = v; ex_btype = bt; ex_flags = fl; ex_pc = epc;
        ex_pred_taken = pr; stat_clr = clr; if_pc = ipc;
        #1;
        cond = (bt >= 3'd1) && (bt <= 3'd5);
        case (bt)
            3'd1: tk = fl[0];
            3'd2: tk = fl[1];
            3'd3: tk = fl[2];
            3'd4: tk = fl[3];
            3'd5: tk = !fl[0];
            3'd6, 3'd7: tk = 1'b1;
            default: tk = 1'b0;
        endcase
        e_take = 0; e_red = 0; e_mp = 0; e_src = 0;
        if (v && !r) begin
            e_take = tk;
            if (cond) begin
                e_mp  = (tk != pr);
                e_red = e_mp;
                e_src = !e_mp ? 0 : (tk ? 1 : 3);
            end else if (bt == 3'd6) begin
                e_red = 1; e_src = 1;
            end else if (bt == 3'd7) begin
                e_red = 1; e_src = 2;
            end
        end
        chk("if_pred_taken", 32'(if_pred_taken), 32'(m_bht[ipc % BHT_DEPTH] >= 2));
        chk("b_take", 32'(b_take), 32'(e_take));
        chk("pc_src", 32'(pc_src), 32'(e_src));
        chk("redirect", 32'(redirect), 32'(e_red));
        chk("mispredict", 32'(mispredict), 32'(e_mp));
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            if (v && cond) begin
                ei = epc % BHT_DEPTH;
                m_bht[ei] = tk ? ((m_bht[ei] + 1 > 3) ? 3 : m_bht[ei] + 1)
                               : ((m_bht[ei] - 1 < 0) ? 0 : m_bht[ei] - 1);
            end
            if (clr) begin
                m_br = 0; m_mp = 0;
            end else if (v && cond) begin
                m_br = (m_br + 1 > CNT_MAX) ? CNT_MAX : m_br + 1;
                if (e_mp) m_mp = (m_mp + 1 > CNT_MAX) ? CNT_MAX : m_mp + 1;
            end
        end
        #1;
        chk("br_count", 32'(br_count), 32'(m_br));
        chk("mp_count", 32'(mp_count), 32'(m_mp));
        $display("step rst=%0b v=%0b bt=%0d fl=%h epc=%0d pr=%0b clr=%0b ipc=%0d -> take=%0b src=%0d red=%0b mp=%0b br=%0d mpc=%0d",
                 r, v, bt, fl, epc, pr, clr, ipc, b_take, pc_src, redirect, mispredict, br_count, mp_count);
    endtask

    task automatic idle(input logic [PC_W-1:0] ipc);
        step(1'b0, 1'b0, 3'd0, 4'h0, 8'd0, 1'b0, 1'b0, ipc);
    endtask

    initial begin
        model_reset();
        // Reset, then a clean sweep of the table.
        step(1'b1, 1'b0, 3'd0, 4'h0, 8'd0, 1'b0, 1'b0, 8'd0);
        step(1'b1, 1'b0, 3'd0, 4'h0, 8'd0, 1'b0, 1'b0, 8'd0);
        for (int i = 0; i < BHT_DEPTH; i++) idle(8'(i));
        chk("reset_br_zero", 32'(br_count), 32'd0);
        chk("reset_mp_zero", 32'(mp_count), 32'd0);

        // JZ taken against a not-taken prediction, then the trained entry reads taken.
        step(1'b0, 1'b1, 3'd1, 4'h1, 8'd3, 1'b0, 1'b0, 8'd3);
        idle(8'd3);
        chk("bht3_taken", 32'(if_pred_taken), 32'd1);

        // LOOP with Z set falls through against a taken prediction, then drive to 00 and hold.
        step(1'b0, 1'b1, 3'd5, 4'h1, 8'd7, 1'b1, 1'b0, 8'd7);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 3'd5, 4'h1, 8'd7, 1'b0, 1'b0, 8'd7);
        chk("bht7_floor", 32'(m_bht[7]), 32'd0);

        // Unconditional transfers leave table and statistics alone.
        step(1'b0, 1'b1, 3'd6, 4'hF, 8'd3, 1'b1, 1'b0, 8'd3);
        step(1'b0, 1'b1, 3'd7, 4'h0, 8'd3, 1'b0, 1'b0, 8'd3);
        idle(8'd3);

        // Saturate the mispredict counter, then clear alongside a mispredict.
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 3'd2, 4'h2, 8'(i), 1'b0, 1'b0, 8'(i));
        chk("mp_saturated", 32'(mp_count), 32'(CNT_MAX));
        step(1'b0, 1'b1, 3'd2, 4'h2, 8'd9, 1'b0, 1'b1, 8'd9);
        chk("clr_br", 32'(br_count), 32'd0);
        chk("clr_mp", 32'(mp_count), 32'd0);

        // Same-index read and train: old value first, new value next cycle.
        step(1'b0, 1'b0, 3'd0, 4'h0, 8'd0, 1'b0, 1'b0, 8'd5);
        step(1'b0, 1'b1, 3'd3, 4'h4, 8'd5, 1'b0, 1'b0, 8'd5);
        step(1'b0, 1'b1, 3'd3, 4'h4, 8'd5, 1'b1, 1'b0, 8'd5);
        idle(8'd5);
        // Reset raised with a live branch in EX discards its training.
        step(1'b1, 1'b1, 3'd3, 4'h4, 8'd5, 1'b0, 1'b0, 8'd5);
        idle(8'd5);
        chk("post_rst_bht5", 32'(if_pred_taken), 32'd0);

        // Random traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            logic [PC_W-1:0] ipc, epc;
            logic pr;
            ipc = 8'($urandom);
            epc = ($urandom_range(0, 1) == 0) ? ipc : 8'($urandom);
            pr  = ($urandom_range(0, 3) == 0) ? 1'($urandom) : 1'(m_bht[epc % BHT_DEPTH] >= 2);
            step(($urandom_range(0, 60) == 0), ($urandom_range(0, 4) != 0), 3'($urandom),
                 4'($urandom), epc, pr, ($urandom_range(0, 30) == 0), ipc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
